// File: rtl/unified_mem_arbiter_if.sv
// Request/response bundle between the pipeline requesters and unified_mem_arbiter.
// Handshake: channel c's request transfers on the clock edge where req_valid[c] & req_ready[c];
// the requester holds req_write/req_addr/req_wdata/req_be of channel c stable until that edge.
// rsp_valid[c] is a one-cycle pulse; rsp_data and rsp_err are meaningful only while it is high.
interface unified_mem_arbiter_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH-1:0]    req_ready;
    logic [NUM_CH-1:0]    req_write;
    logic [NUM_CH*32-1:0] req_addr;
    logic [NUM_CH*32-1:0] req_wdata;
    logic [NUM_CH*4-1:0]  req_be;
    logic [NUM_CH-1:0]    rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter in front of one word-addressed RAM with byte enables, one transaction in flight.
// Define MEM_ARB_ERR_EN to reject out-of-range or misaligned accesses and report them on rsp_err.
module unified_mem_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    unified_mem_arbiter_if.slave bus,
    output logic [1:0]           dbg_state
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW:0] NCH      = (CW+1)'(NUM_CH);
    localparam logic [2:0]  CNT_INIT = 3'((LATENCY > 1) ? LATENCY - 2 : 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [CW-1:0] last_q, last_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic          err_q, err_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          enter_resp;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          grant_found;
    logic [CW-1:0] grant_ch;
    logic          accept;
    logic          sel_write;
    logic          sel_err;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_be;
    logic [AW-1:0] sel_idx;

    // Search starts one past the last granted channel so every waiting channel is served in turn.
    always_comb begin
        logic [CW:0] k;
        grant_found = 1'b0;
        grant_ch    = '0;
        k           = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = {1'b0, last_q} + (CW+1)'(i + 1);
            if (k >= NCH) k = k - NCH;
            if (!grant_found && bus.req_valid[k[CW-1:0]]) begin
                grant_found = 1'b1;
                grant_ch    = k[CW-1:0];
            end
        end
    end

    always_comb begin
        sel_write = bus.req_write[grant_ch];
        sel_wdata = bus.req_wdata[{grant_ch, 5'd0} +: 32];
        sel_be    = bus.req_be[{grant_ch, 2'd0} +: 4];
        sel_idx   = bus.req_addr[{grant_ch, 5'd2} +: AW];
    end

`ifdef MEM_ARB_ERR_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    logic [31:0] sel_addr;

    always_comb begin
        sel_addr = bus.req_addr[{grant_ch, 5'd0} +: 32];
        sel_err  = ({1'b0, sel_addr} >= ADDR_LIMIT)
                || (sel_be == 4'hF && sel_addr[1:0] != 2'b00)
                || ($countones(sel_be) == 2 && sel_addr[0]);
    end
`else
    assign sel_err = 1'b0;
`endif

    assign accept = !reset && (state_q == IDLE) && grant_found;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant_ch] = 1'b1;
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (state_q == RESP) bus.rsp_valid[ch_q] = 1'b1;
    end

    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;
    assign dbg_state    = state_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        last_d     = last_q;
        idx_d      = idx_q;
        write_d    = write_q;
        err_d      = err_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ch_d    = grant_ch;
                    last_d  = grant_ch;
                    idx_d   = sel_idx;
                    write_d = sel_write;
                    err_d   = sel_err;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 3'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // idx_d/write_d/err_d describe the live transaction both at the accept edge and in BUSY.
        if (enter_resp) begin
            rsp_err_d  = err_d;
            rsp_data_d = (write_d || err_d) ? 32'd0 : mem_q[idx_d];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ch_q       <= '0;
            last_q     <= CW'(NUM_CH - 1);
            idx_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            err_q      <= err_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Stores commit at their accept edge; RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (accept && sel_write && !sel_err) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_be[b]) mem_q[sel_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomised and directed bench for unified_mem_arbiter against a transaction-level reference model.
// Build with or without MEM_ARB_ERR_EN; the model follows the same macro.
module tb_unified_mem_arbiter;
    localparam int NUM_CH      = 2;
    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 3;
    localparam int W           = 36;  // {err, ch[2:0], data[31:0]}

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    unified_mem_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

    unified_mem_arbiter #(
        .NUM_CH(NUM_CH), .DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    // requester side
    logic        drv_v  [NUM_CH];
    logic        drv_w  [NUM_CH];
    logic [31:0] drv_a  [NUM_CH];
    logic [31:0] drv_d  [NUM_CH];
    logic [3:0]  drv_be [NUM_CH];

    // reference model and scoreboard
    logic [31:0]  mem_m [DEPTH_WORDS];
    int           m_last;
    int           m_cnt;
    logic [W-1:0] exp_q [$];

    int           n_checks = 0;
    int           n_fail   = 0;
    bit           acc_flag;
    int           acc_ch;
    logic [NUM_CH-1:0] obs_ready;
    logic [31:0]  last_data;
    logic         last_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [3:0] be);
`ifdef MEM_ARB_ERR_EN
        return (a >= 32'(DEPTH_WORDS * 4)) || (be == 4'hF && a[1:0] != 2'b00)
            || ($countones(be) == 2 && a[0]);
`else
        return (a === 32'hx) && (be === 4'hx);
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH_WORDS);
    endfunction

    task automatic drive_bus();
        for (int c = 0; c < NUM_CH; c++) begin
            bus.req_valid[c]         = drv_v[c];
            bus.req_write[c]         = drv_w[c];
            bus.req_addr[32*c +: 32] = drv_a[c];
            bus.req_wdata[32*c +: 32] = drv_d[c];
            bus.req_be[4*c +: 4]     = drv_be[c];
        end
    endtask

    task automatic model_reset();
        m_last = NUM_CH - 1;
        m_cnt  = 0;
        exp_q.delete();
    endtask

    // One clock of the model: check at negedge, then return just after the following posedge.
    task automatic run_cycle();
        logic [NUM_CH-1:0] exp_ready;
        logic [NUM_CH-1:0] exp_valid;
        logic [W-1:0]      e;
        logic [31:0]       rd;
        int                g;
        int                c;
        bit                er;
        @(negedge clock);
        acc_flag  = 1'b0;
        exp_ready = '0;
        exp_valid = '0;
        e         = '0;
        obs_ready = bus.req_ready;
        if (m_cnt == 0) begin
            g = -1;
            for (int i = 0; i < NUM_CH; i++) begin
                c = (m_last + 1 + i) % NUM_CH;
                if (g < 0 && drv_v[c]) g = c;
            end
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                acc_flag     = 1'b1;
                acc_ch       = g;
                m_last       = g;
                m_cnt        = LATENCY;
                er           = is_err(drv_a[g], drv_be[g]);
                rd           = 32'd0;
                if (!er && drv_w[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (drv_be[g][b]) mem_m[widx(drv_a[g])][8*b +: 8] = drv_d[g][8*b +: 8];
                end else if (!er) begin
                    rd = mem_m[widx(drv_a[g])];
                end
                exp_q.push_back({er, 3'(g), rd});
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_valid[e[34:32]] = 1'b1;
                check("rsp_data", bus.rsp_data, e[31:0]);
                check("rsp_err", bus.rsp_err, e[35]);
                last_data = bus.rsp_data;
                last_err  = bus.rsp_err;
            end
        end
        check("req_ready", bus.req_ready, exp_ready);
        check("rsp_valid", bus.rsp_valid, exp_valid);
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * LATENCY + 4; i++)
            if (m_cnt != 0) run_cycle();
    endtask

    task automatic do_txn(input int c, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        drv_v[c] = 1'b1; drv_w[c] = w; drv_a[c] = a; drv_d[c] = d; drv_be[c] = be;
        drive_bus();
        for (int n = 0; n < 4 * (LATENCY + 1) * NUM_CH; n++) begin
            run_cycle();
            if (acc_flag && acc_ch == c) break;
        end
        drv_v[c] = 1'b0;
        drive_bus();
        drain();
    endtask

    task automatic new_req(input int c);
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) * 32'd4;
        if ($urandom_range(0, 3) == 0) a = a + 32'h1000 * 32'($urandom_range(1, 7));
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
        drv_v[c] = 1'b1;
        drv_w[c] = 1'($urandom_range(0, 1));
        drv_a[c] = a;
        drv_d[c] = $urandom;
        case ($urandom_range(0, 5))
            0, 1:    drv_be[c] = 4'hF;
            2:       drv_be[c] = 4'h3;
            3:       drv_be[c] = 4'hC;
            default: drv_be[c] = 4'($urandom_range(1, 15));
        endcase
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clock);
            check("rst_rsp_valid_held", bus.rsp_valid, '0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic reset_mid(input int c, input bit w, input logic [31:0] a, input logic [31:0] d);
        drv_v[c] = 1'b1; drv_w[c] = w; drv_a[c] = a; drv_d[c] = d; drv_be[c] = 4'hF;
        drive_bus();
        for (int n = 0; n < 4 * (LATENCY + 1) * NUM_CH; n++) begin
            run_cycle();
            if (acc_flag && acc_ch == c) break;
        end
        drv_v[c] = 1'b0;
        drive_bus();
        reset = 1'b1;
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, '0);
        check("midrst_rsp_data", bus.rsp_data, 32'd0);
        check("midrst_rsp_err", bus.rsp_err, 1'b0);
        check("midrst_req_ready", bus.req_ready, '0);
        apply_reset();
        for (int n = 0; n < LATENCY + 2; n++) run_cycle();
    endtask

    initial begin
        logic [31:0] w0;
        int          exp_g;
        for (int c = 0; c < NUM_CH; c++) begin
            drv_v[c] = 1'b0; drv_w[c] = 1'b0; drv_a[c] = '0; drv_d[c] = '0; drv_be[c] = '0;
        end
        drive_bus();
        model_reset();
        #1;
        check("reset_rsp_valid", bus.rsp_valid, '0);
        check("reset_rsp_data", bus.rsp_data, 32'd0);
        check("reset_rsp_err", bus.rsp_err, 1'b0);
        check("reset_req_ready", bus.req_ready, '0);
        apply_reset();

        for (int i = 0; i < 16; i++) do_txn(0, 1'b1, 32'(i * 4), $urandom, 4'hF);

        do_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'hF);
        check("store_then_load", last_data, 32'hDEADBEEF);

        do_txn(1, 1'b1, 32'h20, 32'h11223344, 4'hF);
        do_txn(1, 1'b1, 32'h20, 32'h0000AB00, 4'b0010);
        do_txn(0, 1'b0, 32'h20, 32'h0, 4'hF);
        check("partial_store", last_data, 32'h1122AB44);

        w0 = mem_m[0];
        do_txn(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF);
`ifdef MEM_ARB_ERR_EN
        check("oob_store_err", last_err, 1'b1);
        do_txn(1, 1'b0, 32'h0, 32'h0, 4'hF);
        check("oob_store_no_write", last_data, w0);
        do_txn(1, 1'b0, 32'h2, 32'h0, 4'hF);
        check("misaligned_err", last_err, 1'b1);
`else
        do_txn(1, 1'b0, 32'h0, 32'h0, 4'hF);
        check("alias_store", last_data, 32'hCAFEF00D);
        do_txn(1, 1'b0, 32'h2, 32'h0, 4'hF);
        check("low_bits_ignored", last_data, 32'hCAFEF00D);
`endif

        reset_mid(1, 1'b0, 32'h10, 32'h0);
        reset_mid(0, 1'b1, 32'h30, 32'h5A5AA5A5);
        do_txn(1, 1'b0, 32'h30, 32'h0, 4'hF);
        check("store_survives_reset", last_data, 32'h5A5AA5A5);

        // both channels request continuously from reset: grants must alternate starting at ch0
        reset = 1'b1;
        new_req(0);
        new_req(1);
        drive_bus();
        apply_reset();
        exp_g = 0;
        for (int n = 0; n < 6 * (LATENCY + 1); n++) begin
            run_cycle();
            if (acc_flag) begin
                check("rr_grant", obs_ready, (exp_g == 0) ? 2'b01 : 2'b10);
                exp_g = 1 - exp_g;
                new_req(acc_ch);
                drive_bus();
            end
        end

        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NUM_CH; c++)
                if (!drv_v[c] && $urandom_range(0, 3) == 0) new_req(c);
            drive_bus();
            run_cycle();
            if (acc_flag) begin
                if ($urandom_range(0, 1) == 1) new_req(acc_ch);
                else drv_v[acc_ch] = 1'b0;
                drive_bus();
            end
        end
        for (int c = 0; c < NUM_CH; c++) drv_v[c] = 1'b0;
        drive_bus();
        drain();
        for (int n = 0; n < 2; n++) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
